hardware_serial_word_rx: RTL and testbench

- Bit-serial receiver. It deserializes a single-bit asynchronous line into DATA_W-bit words and presents them on a valid/ready interface.
- It is the ingress counterpart of the top-level single-bit output path. It loads SKI program/term words from an external serial source into the reduction machine.
- Framing: start bit, then DATA_W data bits LSB first, then one stop bit.
- One output holding register decouples the line timing from the consumer.

---
 rtl/hardware_rx_pkg.sv | 14 +
 rtl/hardware_rx_sync.sv | 15 +
 rtl/hardware_serial_word_rx.sv | 108 ++++++++++
 tb/tb_hardware_serial_word_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hardware_rx_pkg.sv
// hardware_rx_pkg: FSM states, default parameters and width helpers for the serial word receiver.
package hardware_rx_pkg;
  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;
  function automatic int tmr_w(input int cpb);
    return $clog2(cpb);
  endfunction
  function automatic int idx_w(input int dw);
    return $clog2(dw + 1);
  endfunction
  localparam int TMR_W_DEF = tmr_w(CLKS_PER_BIT_DEF);
  localparam int IDX_W_DEF = idx_w(DATA_W_DEF);
endpackage

// File: rtl/hardware_rx_sync.sv
// hardware_rx_sync: two-flop synchronizer for the idle-high serial line; resets to 1 so reset looks like idle.
module hardware_rx_sync
  import hardware_rx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ff_q <= 2'b11;
    else ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/hardware_serial_word_rx.sv
// hardware_serial_word_rx: start/DATA_W LSB-first/stop serial receiver with a one-word valid/ready holding register.
// Optional even-parity bit between data and stop when HARDWARE_RX_PARITY_EN is defined.
module hardware_serial_word_rx
  import hardware_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              rx_i,
  output logic [DATA_W-1:0] word_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              parity_err_o
);
  localparam int TW = tmr_w(CLKS_PER_BIT);
  localparam int IW = idx_w(DATA_W);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
  rx_state_e state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d, word_q, word_d;
  logic valid_q, valid_d;
  logic rx_s, tick, par_ok, perr;
  hardware_rx_sync u_sync (
    .clk_i (system1000),
    .rst_ni(system1000_rstn),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );
`ifdef HARDWARE_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = PARITY;
  logic par_q, par_d;
  assign par_ok = ~^{shift_q, par_q};
  always_ff @(posedge system1000 or negedge system1000_rstn)
    if (!system1000_rstn) par_q <= 1'b0;
    else par_q <= par_d;
  always_comb par_d = (state_q == PARITY && tick) ? rx_s : par_q;
`else
  localparam rx_state_e AFTER_DATA = STOP;
  assign par_ok = 1'b1;
`endif
  assign tick = tmr_q == '0;
  always_comb begin
    state_d = state_q;
    tmr_d = tick ? FULL : tmr_q - 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    word_d = word_q;
    valid_d = valid_q & ~ready_i;
    frame_err_o = 1'b0;
    overrun_o = 1'b0;
    perr = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        tmr_d = HALF;
      end
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        idx_d = '0;
      end
      DATA: if (tick) begin
        shift_d = (shift_q >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == LAST) ? AFTER_DATA : DATA;
      end
      PARITY: if (tick) state_d = STOP;
      STOP: if (tick) begin
        state_d = rx_s ? IDLE : BREAK;
        frame_err_o = ~rx_s;
        perr = rx_s & ~par_ok;
        // a stalled consumer never blocks the line: the new word is dropped instead
        if (rx_s && par_ok) begin
          overrun_o = valid_q & ~ready_i;
          word_d = overrun_o ? word_q : shift_q;
          valid_d = 1'b1;
        end
      end
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge system1000 or negedge system1000_rstn)
    if (!system1000_rstn) begin
      state_q <= IDLE;
      tmr_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      word_q <= word_d;
      valid_q <= valid_d;
    end
  assign word_o = word_q;
  assign valid_o = valid_q;
  assign parity_err_o = perr;
endmodule

// File: tb/tb_hardware_serial_word_rx.sv
// tb_hardware_serial_word_rx: table-driven and hand-sequenced checks of the serial word receiver with a word scoreboard.
module tb_hardware_serial_word_rx;
  localparam int CPB = 16;
`ifdef HARDWARE_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAT = 2 + CPB / 2 + (9 + PAR) * CPB + 1;
  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         del;
  } vec_t;
  logic clk, rst_n, rx, ready;
  logic [7:0] word;
  logic valid, ferr, ovr, perr;
  int n_chk = 0, n_fail = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  logic [7:0] exp_q[$];
  hardware_serial_word_rx dut (
    .system1000     (clk),
    .system1000_rstn(rst_n),
    .rx_i           (rx),
    .word_o         (word),
    .valid_o        (valid),
    .ready_i        (ready),
    .frame_err_o    (ferr),
    .overrun_o      (ovr),
    .parity_err_o   (perr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input bit stop, input bit bad_par);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR != 0) begin
      rx = ^d ^ bad_par;
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask
  // transfers and pulses are observed just after the input drive point, i.e. what the next rising edge will see
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (ferr) n_ferr++;
      if (ovr) n_ovr++;
      if (perr) n_perr++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: actual %0h required none", word);
        end else check("sb_word", word, exp_q.pop_front());
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[6];
    int lat, f0, o0, p0;
    tbl[0] = '{8'h00, 1'b1, 1'b1};
    tbl[1] = '{8'hFF, 1'b1, 1'b1};
    tbl[2] = '{8'h5A, 1'b1, 1'b1};
    tbl[3] = '{8'hC3, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b1, 1'b1};
    tbl[5] = '{8'h80, 1'b1, 1'b1};
    rst_n = 1'b0;
    rx = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_word", word, 0);
    check("rst_pulses", {ferr, ovr, perr}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send(8'hA5, 1'b1, 1'b0);
      begin
        for (int i = 1; i <= 300; i++) begin
          @(negedge clk);
          if (valid) begin
            lat = i;
            break;
          end
        end
        check("t1_latency", lat, LAT);
        check("t1_word", word, 8'hA5);
        @(negedge clk);
        check("t1_one_cycle", valid, 0);
      end
    join
    repeat (5) @(negedge clk);
    foreach (tbl[i]) begin
      f0 = n_ferr;
      if (tbl[i].del) exp_q.push_back(tbl[i].d);
      send(tbl[i].d, tbl[i].stop, 1'b0);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check($sformatf("tbl%0d_ferr", i), n_ferr - f0, int'(!tbl[i].stop));
      check($sformatf("tbl%0d_drained", i), exp_q.size(), 0);
    end
    f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("t2_valid", valid, 0);
    check("t2_pulses", (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0), 0);
    exp_q.push_back(8'h96);
    send(8'h96, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("t2_next_frame", exp_q.size(), 0);
    f0 = n_ferr;
    send(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("t3_ferr", n_ferr - f0, 1);
    check("t3_only_81", exp_q.size(), 0);
    ready = 1'b0;
    o0 = n_ovr;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("t4_valid", valid, 1);
    check("t4_word_held", word, 8'h11);
    check("t4_overrun", n_ovr - o0, 1);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_valid_drop", valid, 0);
    check("t4_drained", exp_q.size(), 0);
    ready = 1'b0;
    exp_q.push_back(8'h44);
    send(8'h44, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("t5_held", word, 8'h44);
    o0 = n_ovr;
    exp_q.push_back(8'h55);
    fork
      send(8'h55, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        check("t5_valid", valid, 1);
        check("t5_word", word, 8'h55);
        ready = 1'b0;
      end
    join
    check("t5_no_overrun", n_ovr - o0, 0);
    check("t5_pending", exp_q.size(), 1);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_drained", exp_q.size(), 0);
    f0 = n_ferr; p0 = n_perr;
    fork
      send(8'hFF, 1'b1, 1'b0);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_async_word", word, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    check("t6_no_pulse", (n_ferr - f0) + (n_perr - p0), 0);
    check("t6_no_word", valid, 0);
`ifdef HARDWARE_RX_PARITY_EN
    send(8'h0F, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_perr", n_perr - p0, 1);
    check("t6_par_no_word", valid, 0);
`else
    exp_q.push_back(8'h0F);
    send(8'h0F, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("t6_perr_tied", n_perr - p0, 0);
`endif
    check("final_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
